// File: rtl/counter.sv
// rtl/counter.sv - up/down counter with programmable start, terminal and step
// Behavioral and structural implementations, selected at build time, are cycle-identical.
`timescale 1ns/1ps
module counter #(
    parameter                  ARCHITECTURE = "BEHAVIORAL",
    parameter int              DATA_WIDTH   = 8,
    parameter longint unsigned COUNT_FROM   = 0,
    parameter longint unsigned COUNT_TO     = 255,
    parameter longint unsigned STEP         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] FROM_W = COUNT_FROM[W-1:0];
    localparam logic [W-1:0] TO_W   = COUNT_TO[W-1:0];
    localparam logic [W-1:0] STEP_W = STEP[W-1:0];
    localparam logic [W-1:0] ONE_W  = 1;
    localparam bit           UP     = (TO_W >= FROM_W);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign out = count_q;

    if (W < 1 || W > 64) begin : g_bad_width
        $error("counter: DATA_WIDTH must be 1..64");
    end
    if (W < 64 && ((COUNT_FROM >> W) != 0 || (COUNT_TO >> W) != 0 || (STEP >> W) != 0)) begin : g_bad_range
        $error("counter: COUNT_FROM, COUNT_TO and STEP must fit in DATA_WIDTH");
    end
    if (STEP_W == '0) begin : g_bad_step
        $error("counter: STEP must be non-zero");
    end

    if (ARCHITECTURE == "BEHAVIORAL") begin : g_beh
        logic [W:0] sum_up;
        logic [W:0] lim_dn;
        logic       wrap;

        assign sum_up = {1'b0, count_q} + {1'b0, STEP_W};
        assign lim_dn = {1'b0, TO_W} + {1'b0, STEP_W};
        assign wrap   = (count_q == TO_W) ||
                        (UP ? (sum_up > {1'b0, TO_W}) : ({1'b0, count_q} < lim_dn));

        always_comb begin
            count_d = count_q;
            if (en) begin
                if (wrap) count_d = FROM_W;
                else      count_d = UP ? sum_up[W-1:0] : (count_q - STEP_W);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) count_q <= FROM_W;
            else     count_q <= count_d;
        end
    end else if (ARCHITECTURE == "STRUCTURAL") begin : g_str
        // Down mode adds the two's complement of STEP; a missing carry-out means a borrow.
        localparam logic [W-1:0] ADD_B = UP ? STEP_W : (~STEP_W + ONE_W);

        logic [W:0]   carry;
        logic [W-1:0] sum;
        logic [W:0]   gt_c;
        logic [W:0]   lt_c;
        logic [W:0]   eq_c;
        logic         wrap;

        assign carry[0] = 1'b0;
        assign gt_c[0]  = 1'b0;
        assign lt_c[0]  = 1'b0;
        assign eq_c[0]  = 1'b1;

        for (genvar i = 0; i < W; i++) begin : g_bit
            logic bit_q;

            assign sum[i]     = count_q[i] ^ ADD_B[i] ^ carry[i];
            assign carry[i+1] = (count_q[i] & ADD_B[i]) | (carry[i] & (count_q[i] ^ ADD_B[i]));
            assign gt_c[i+1]  = (sum[i] & ~TO_W[i]) | (~(sum[i] ^ TO_W[i]) & gt_c[i]);
            assign lt_c[i+1]  = (~sum[i] & TO_W[i]) | (~(sum[i] ^ TO_W[i]) & lt_c[i]);
            assign eq_c[i+1]  = eq_c[i] & ~(count_q[i] ^ TO_W[i]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) bit_q <= FROM_W[i];
                else     bit_q <= count_d[i];
            end
            assign count_q[i] = bit_q;
        end

        assign wrap = UP ? (eq_c[W] | carry[W] | gt_c[W])
                         : (eq_c[W] | ~carry[W] | lt_c[W]);

        always_comb begin
            count_d = count_q;
            if (en) count_d = wrap ? FROM_W : sum;
        end
    end else begin : g_bad_arch
        $error("counter: ARCHITECTURE must be BEHAVIORAL or STRUCTURAL");
    end
endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter, both architectures
`timescale 1ns/1ps
module tb_counter;
    logic clk;
    logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
    logic [7:0] a_b, a_s, os_b, os_s, dn1_b, dn1_s, dn2_b, dn2_s, dg_b, dg_s;
    logic [3:0] c1_b, c1_s, c2_b, c2_s;

    typedef struct {
        int          cyc;
        int          ch;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    int os_seq [4] = '{3, 8, 13, 18};
    int dn1_seq[3] = '{10, 7, 4};
    int dn2_seq[3] = '{9, 6, 3};

    counter #(.ARCHITECTURE("BEHAVIORAL")) u_a_b (.clk(clk), .rst(rst_a), .en(en_a), .out(a_b));
    counter #(.ARCHITECTURE("STRUCTURAL")) u_a_s (.clk(clk), .rst(rst_a), .en(en_a), .out(a_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(7), .COUNT_TO(7), .STEP(3))
        u_dg_b (.clk(clk), .rst(rst_a), .en(en_a), .out(dg_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(7), .COUNT_TO(7), .STEP(3))
        u_dg_s (.clk(clk), .rst(rst_a), .en(en_a), .out(dg_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(3), .COUNT_TO(20), .STEP(5))
        u_os_b (.clk(clk), .rst(rst_b), .en(en_b), .out(os_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(3), .COUNT_TO(20), .STEP(5))
        u_os_s (.clk(clk), .rst(rst_b), .en(en_b), .out(os_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(10), .COUNT_TO(2), .STEP(3))
        u_dn1_b (.clk(clk), .rst(rst_b), .en(en_b), .out(dn1_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(10), .COUNT_TO(2), .STEP(3))
        u_dn1_s (.clk(clk), .rst(rst_b), .en(en_b), .out(dn1_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .COUNT_FROM(9), .COUNT_TO(3), .STEP(3))
        u_dn2_b (.clk(clk), .rst(rst_b), .en(en_b), .out(dn2_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .COUNT_FROM(9), .COUNT_TO(3), .STEP(3))
        u_dn2_s (.clk(clk), .rst(rst_b), .en(en_b), .out(dn2_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(4), .COUNT_FROM(0), .COUNT_TO(15), .STEP(1))
        u_c1_b (.clk(clk), .rst(rst_c), .en(en_c), .out(c1_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(4), .COUNT_FROM(0), .COUNT_TO(15), .STEP(1))
        u_c1_s (.clk(clk), .rst(rst_c), .en(en_c), .out(c1_s));
    counter #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(4), .COUNT_FROM(5), .COUNT_TO(12), .STEP(2))
        u_c2_b (.clk(clk), .rst(rst_c), .en(en_c), .out(c2_b));
    counter #(.ARCHITECTURE("STRUCTURAL"), .DATA_WIDTH(4), .COUNT_FROM(5), .COUNT_TO(12), .STEP(2))
        u_c2_s (.clk(clk), .rst(rst_c), .en(en_c), .out(c2_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ch_val(int ch);
        case (ch)
            0:  return 64'(a_b);
            1:  return 64'(a_s);
            2:  return 64'(os_b);
            3:  return 64'(os_s);
            4:  return 64'(dn1_b);
            5:  return 64'(dn1_s);
            6:  return 64'(dn2_b);
            7:  return 64'(dn2_s);
            8:  return 64'(dg_b);
            9:  return 64'(dg_s);
            10: return 64'(c1_b);
            11: return 64'(c1_s);
            12: return 64'(c2_b);
            13: return 64'(c2_s);
            default: return 64'hdead;
        endcase
    endfunction

    function automatic string ch_name(int ch);
        case (ch)
            0:  return "def_beh";
            1:  return "def_str";
            2:  return "ovr_beh";
            3:  return "ovr_str";
            4:  return "dn10_2_beh";
            5:  return "dn10_2_str";
            6:  return "dn9_3_beh";
            7:  return "dn9_3_str";
            8:  return "degen_beh";
            9:  return "degen_str";
            10: return "w4_0_15_beh";
            11: return "w4_0_15_str";
            12: return "w4_5_12_beh";
            13: return "w4_5_12_str";
            default: return "unknown";
        endcase
    endfunction

    // Reference next-count for the random-stimulus configurations.
    function automatic longint unsigned mnext(longint unsigned o, longint unsigned f,
                                              longint unsigned t, longint unsigned s);
        if (t >= f) begin
            if (o == t || o + s > t) return f;
            return o + s;
        end
        if (o == t || o < t + s) return f;
        return o - s;
    endfunction

    task automatic push(int c, int ch, logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check_now(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge; entries are due at their cycle tag.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [63:0] act;
            e   = exp_q.pop_front();
            act = ch_val(e.ch);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%0d required=%0d", ch_name(e.ch), e.cyc, act, e.val);
            end
        end
    end

    int m_a, k_b;
    longint unsigned m_c1, m_c2;

    task automatic step_a(bit e, bit r);
        @(negedge clk);
        #1;
        en_a  = e;
        rst_a = r;
        if (r)      m_a = 0;
        else if (e) m_a = (m_a + 1) % 256;
        push(cyc + 1, 0, 64'(m_a));
        push(cyc + 1, 1, 64'(m_a));
        push(cyc + 1, 8, 64'd7);
        push(cyc + 1, 9, 64'd7);
    endtask

    task automatic step_b(bit e, bit r);
        @(negedge clk);
        #1;
        en_b  = e;
        rst_b = r;
        if (r)      k_b = 0;
        else if (e) k_b++;
        push(cyc + 1, 2, 64'(os_seq[k_b % 4]));
        push(cyc + 1, 3, 64'(os_seq[k_b % 4]));
        push(cyc + 1, 4, 64'(dn1_seq[k_b % 3]));
        push(cyc + 1, 5, 64'(dn1_seq[k_b % 3]));
        push(cyc + 1, 6, 64'(dn2_seq[k_b % 3]));
        push(cyc + 1, 7, 64'(dn2_seq[k_b % 3]));
    endtask

    task automatic step_c(bit e, bit r);
        @(negedge clk);
        #1;
        en_c  = e;
        rst_c = r;
        if (r) begin
            m_c1 = 0;
            m_c2 = 5;
        end else if (e) begin
            m_c1 = mnext(m_c1, 0, 15, 1);
            m_c2 = mnext(m_c2, 5, 12, 2);
        end
        push(cyc + 1, 10, 64'(m_c1));
        push(cyc + 1, 11, 64'(m_c1));
        push(cyc + 1, 12, 64'(m_c2));
        push(cyc + 1, 13, 64'(m_c2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_a    = 0;
        k_b    = 0;
        m_c1   = 0;
        m_c2   = 5;
        rst_a  = 1'b1; en_a = 1'b0;
        rst_b  = 1'b1; en_b = 1'b0;
        rst_c  = 1'b1; en_c = 1'b0;

        // Defaults: full-range wrap 255 -> 0.
        step_a(0, 1);
        step_a(1, 1);
        for (int i = 0; i < 300; i++) step_a(1, 0);

        // Enable gating: hold at 10 for five cycles.
        step_a(0, 1);
        step_a(0, 1);
        for (int i = 0; i < 10; i++) step_a(1, 0);
        for (int i = 0; i < 5; i++)  step_a(0, 0);
        for (int i = 0; i < 27; i++) step_a(1, 0);

        // Asynchronous reset between edges while out is 37.
        @(negedge clk);
        #2;
        rst_a = 1'b1;
        en_a  = 1'b1;
        #1;
        check_now("async_rst_beh", 64'(a_b), 64'd0);
        check_now("async_rst_str", 64'(a_s), 64'd0);
        m_a = 0;
        push(cyc + 1, 0, 64'd0);
        push(cyc + 1, 1, 64'd0);
        push(cyc + 1, 8, 64'd7);
        push(cyc + 1, 9, 64'd7);
        step_a(1, 1);
        step_a(1, 1);
        for (int i = 0; i < 4; i++) step_a(1, 0);

        // Overshoot and down-counting tables.
        step_b(0, 1);
        step_b(1, 1);
        for (int i = 0; i < 9; i++) step_b(1, 0);
        step_b(0, 0);
        step_b(0, 0);
        for (int i = 0; i < 6; i++) step_b(1, 0);

        // Random enable/reset on the 4-bit configurations.
        step_c(0, 1);
        for (int i = 0; i < 1000; i++)
            step_c($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
